// File: rtl/bmu_result_collector.sv
// bmu_result_collector
// Response-side companion of the Bit Manipulation Unit. Every op issued to the
// BMU is tracked through a LATENCY-deep {valid,tag} pipe; when the op reaches
// the end of the pipe, the BMU's registered result and error are captured with
// the tag into a DEPTH-entry FIFO, which drains in issue order to writeback.
// Issue credit counts FIFO entries plus ops still in flight, so a capture can
// never find the FIFO full.
//
// Optional feature: define BMU_RC_ERRCNT_EN to add the err_count port, a
// saturating 16-bit count of captured ops that carried bmu_error=1.
//
// Handshakes: issue side transfers when issue_valid & issue_ready at posedge;
// output side transfers (pops) when out_valid & out_ready at posedge. While
// out_valid is high and out_ready low, out_data/out_error/out_tag hold steady.
module bmu_result_collector #(
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic [TAG_W-1:0]       issue_tag,
    output logic                   issue_ready,
    input  logic [31:0]            bmu_result_ff,
    input  logic                   bmu_error,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_data,
    output logic                   out_error,
    output logic [TAG_W-1:0]       out_tag,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   overflow
`ifdef BMU_RC_ERRCNT_EN
    ,
    output logic [15:0]            err_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Tracking pipe: one {valid,tag} per cycle of BMU latency.
    logic [LATENCY-1:0] pipe_valid;
    logic [TAG_W-1:0]   pipe_tag [LATENCY];

    // FIFO storage and pointers.
    logic [31:0]      mem_data  [DEPTH];
    logic             mem_error [DEPTH];
    logic [TAG_W-1:0] mem_tag   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic        push;
    logic        pop;
    logic [31:0] inflight;
    logic [31:0] credit_sum;

    // Capture happens when the op issued LATENCY cycles ago reaches the pipe end.
    assign push = pipe_valid[LATENCY-1];
    assign pop  = out_valid & out_ready;

    // Pipe valid bits: stage 0 takes only accepted issues, later stages shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= issue_valid & issue_ready;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    // Pipe tags travel alongside the valid bits; qualified by them, so no reset.
    always_ff @(posedge clk) begin
        pipe_tag[0] <= issue_tag;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_tag[i] <= pipe_tag[i-1];
        end
    end

    // Credit: FIFO entries plus in-flight ops must stay below DEPTH. A pop in
    // this cycle is deliberately ignored; the freed slot shows next cycle.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + 32'(pipe_valid[i]);
        end
        credit_sum  = 32'(occupancy) + inflight;
        issue_ready = credit_sum < 32'(DEPTH);
    end

    // FIFO write port: the BMU result is valid exactly when the pipe end is.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr]  <= bmu_result_ff;
            mem_error[wr_ptr] <= bmu_error;
            mem_tag[wr_ptr]   <= pipe_tag[LATENCY-1];
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave occupancy alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Sticky flag for an issuer that ignored the credit signal.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (issue_valid && !issue_ready) begin
            overflow <= 1'b1;
        end
    end

    // Head of FIFO; forced to zero while empty so reset presents clean outputs.
    always_comb begin
        out_valid = (occupancy != '0);
        out_data  = out_valid ? mem_data[rd_ptr]  : 32'd0;
        out_error = out_valid ? mem_error[rd_ptr] : 1'b0;
        out_tag   = out_valid ? mem_tag[rd_ptr]   : '0;
    end

`ifdef BMU_RC_ERRCNT_EN
    // Saturating count of captured ops that reported a BMU error.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= 16'd0;
        end else if (push && bmu_error && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

    // The credit rule must make a push into a full FIFO unreachable.
    assert property (@(posedge clk) disable iff (rst)
                     !(push && (occupancy == CNT_W'(DEPTH))))
        else $error("bmu_result_collector: push into full FIFO");

endmodule

// File: tb/tb_bmu_result_collector.sv
// Directed testbench for bmu_result_collector (LATENCY=1, DEPTH=4, TAG_W=4).
// The bench plays the BMU: it drives bmu_result_ff/bmu_error in the cycle after
// each issue. An output monitor compares every popped head against an expected
// queue filled by the directed sequences.
module tb_bmu_result_collector;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [3:0]  issue_tag;
    logic        issue_ready;
    logic [31:0] bmu_result_ff;
    logic        bmu_error;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_error;
    logic [3:0]  out_tag;
    logic [2:0]  occupancy;
    logic        overflow;
`ifdef BMU_RC_ERRCNT_EN
    logic [15:0] err_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Expected output entries: {error, data, tag}.
    logic [36:0] exp_q[$];

    bmu_result_collector #(
        .LATENCY(1),
        .DEPTH  (4),
        .TAG_W  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_tag    (issue_tag),
        .issue_ready  (issue_ready),
        .bmu_result_ff(bmu_result_ff),
        .bmu_error    (bmu_error),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_error    (out_error),
        .out_tag      (out_tag),
        .occupancy    (occupancy),
        .overflow     (overflow)
`ifdef BMU_RC_ERRCNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    // Clock and reset block.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and checks happen 1 time unit after posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] tag, input logic [31:0] res, input logic err);
        issue_valid   = v;
        issue_tag     = tag;
        bmu_result_ff = res;
        bmu_error     = err;
    endtask

    // Output monitor: each accepted head must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_output", 64'({out_error, out_data, out_tag}), 64'(37'h1FFFFFFFFF));
            end else begin
                check("out_head", 64'({out_error, out_data, out_tag}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 1'b0);

        // Reset: two cycles high, then release.
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_occupancy", 64'(occupancy), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_issue_ready", 64'(issue_ready), 64'(1));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_tag", 64'(out_tag), 64'(0));
`ifdef BMU_RC_ERRCNT_EN
        check("rst_err_count", 64'(err_count), 64'(0));
`endif

        // Single op: issue tag 3 at edge N, result in cycle N+1, visible at N+2.
        out_ready = 1'b1;
        drive(1'b1, 4'd3, 32'd0, 1'b0);
        tick();
        exp_q.push_back({1'b0, 32'hDEADBEEF, 4'd3});
        drive(1'b0, 4'd0, 32'hDEADBEEF, 1'b0);
        check("single_not_yet", 64'(out_valid), 64'(0));
        tick();
        drive(1'b0, 4'd0, 32'd0, 1'b0);
        check("single_valid", 64'(out_valid), 64'(1));
        check("single_data", 64'(out_data), 64'(32'hDEADBEEF));
        check("single_tag", 64'(out_tag), 64'(3));
        check("single_error", 64'(out_error), 64'(0));
        tick();
        check("single_popped", 64'(occupancy), 64'(0));

        // Backpressure: four back-to-back ops with out_ready low.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_ready_%0d", i), 64'(issue_ready), 64'(1));
            drive(1'b1, 4'(i), (i == 0) ? 32'd0 : 32'h1000 + 32'(i - 1), 1'b0);
            if (i > 0) exp_q.push_back({1'b0, 32'h1000 + 32'(i - 1), 4'(i - 1)});
            tick();
        end
        check("bp_ready_after_4th", 64'(issue_ready), 64'(0));
        drive(1'b0, 4'd0, 32'h1003, 1'b0);
        exp_q.push_back({1'b0, 32'h1003, 4'd3});
        tick();
        check("bp_occ_full", 64'(occupancy), 64'(4));
        check("bp_ready_full", 64'(issue_ready), 64'(0));
        check("bp_head_held", 64'(out_tag), 64'(0));

        // Overflow: issue tag 7 without credit; it must never be captured.
        drive(1'b1, 4'd7, 32'h7777, 1'b0);
        tick();
        check("ovf_set", 64'(overflow), 64'(1));
        drive(1'b0, 4'd0, 32'h7777, 1'b0);
        tick();
        check("ovf_sticky", 64'(overflow), 64'(1));
        check("ovf_not_tracked", 64'(occupancy), 64'(4));

        // Drain in order; credit returns one cycle after the first pop.
        out_ready = 1'b1;
        check("drain_ready_before", 64'(issue_ready), 64'(0));
        tick();
        check("drain_ready_after_pop", 64'(issue_ready), 64'(1));
        check("drain_occ_3", 64'(occupancy), 64'(3));
        for (int b = 0; b < 10 && occupancy != 3'd0; b++) tick();
        check("drain_empty_valid", 64'(out_valid), 64'(0));
        check("drain_occ_0", 64'(occupancy), 64'(0));
        check("drain_exp_left", 64'(exp_q.size()), 64'(0));
        check("ovf_still_set", 64'(overflow), 64'(1));

        // Error path with streaming push and pop: errors 1,0,1.
        drive(1'b1, 4'd1, 32'd0, 1'b0);
        tick();
        exp_q.push_back({1'b1, 32'h0000_00A0, 4'd1});
        drive(1'b1, 4'd2, 32'h0000_00A0, 1'b1);
        tick();
        exp_q.push_back({1'b0, 32'h0000_00A1, 4'd2});
        drive(1'b1, 4'd3, 32'h0000_00A1, 1'b0);
        tick();
        check("pp_occ_a", 64'(occupancy), 64'(1));
        exp_q.push_back({1'b1, 32'h0000_00A2, 4'd3});
        drive(1'b0, 4'd0, 32'h0000_00A2, 1'b1);
        tick();
        check("pp_occ_b", 64'(occupancy), 64'(1));
        drive(1'b0, 4'd0, 32'd0, 1'b0);
        tick();
        check("err_drained", 64'(occupancy), 64'(0));
        check("err_exp_left", 64'(exp_q.size()), 64'(0));
`ifdef BMU_RC_ERRCNT_EN
        check("err_count_2", 64'(err_count), 64'(2));
`endif

        // Reset mid-flight: two ops in the FIFO, one in the pipe.
        out_ready = 1'b0;
        drive(1'b1, 4'd8, 32'd0, 1'b0);
        tick();
        drive(1'b1, 4'd9, 32'h0000_00B0, 1'b1);
        tick();
        drive(1'b1, 4'd10, 32'h0000_00B1, 1'b0);
        tick();
        check("mid_occ_2", 64'(occupancy), 64'(2));
        rst = 1'b1;
        drive(1'b0, 4'd0, 32'h0000_00B2, 1'b1);
        tick();
        rst = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 1'b0);
        check("mid_occ_0", 64'(occupancy), 64'(0));
        check("mid_valid_0", 64'(out_valid), 64'(0));
        check("mid_ovf_clr", 64'(overflow), 64'(0));
        check("mid_ready", 64'(issue_ready), 64'(1));
`ifdef BMU_RC_ERRCNT_EN
        check("mid_err_count", 64'(err_count), 64'(0));
`endif
        tick();
        check("mid_no_push", 64'(occupancy), 64'(0));
        out_ready = 1'b1;
        tick();
        tick();
        check("mid_still_empty", 64'(out_valid), 64'(0));
        check("final_exp_left", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
